anabellek_hakem: RTL
====================

ANABELLEK_HAKEM -- requirements
Module: anabellek_hakem

Interface
REQ-001 Parameter ZAMAN_ASIMI, default 255: iomem_ready wait limit in cycles, range 1..255.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 l1b_valid_i  input  1; l1b_addr_i  input  17 [18:2]: instruction-cache read request, word address.
REQ-005 l1b_ready_o  output  1; l1b_rdata_o  output  32: one-cycle completion pulse and read data.
REQ-006 l1v_valid_i  input  1; l1v_wstrb_i  input  4; l1v_addr_i  input  17 [18:2]; l1v_wdata_i  input  32: data-cache request; wstrb 0 = read.
REQ-007 l1v_ready_o  output  1; l1v_rdata_o  output  32: one-cycle completion pulse and read data.
REQ-008 iomem_valid  output  1; iomem_ready  input  1; iomem_wstrb  output  4; iomem_addr  output  32; iomem_wdata  output  32; iomem_rdata  input  32: main-memory port.
REQ-009 hata_o  output  1: pulses with a requester ready when that transaction timed out.

Function
REQ-010 FSM states SHALL be BOS, L1B_AKTIF, L1V_AKTIF, BITTI.
REQ-011 BOS: no valid -> stay; else grant per REQ-018/019, latch grantee addr/wstrb/wdata, go to grantee AKTIF state.
REQ-012 iomem_valid SHALL be a register, high exactly in AKTIF states; grant sampled at edge 0 -> iomem_valid high from edge 0.
REQ-013 iomem_addr SHALL equal {13'b0, latched addr, 2'b00}; iomem_wstrb/wdata latched values; L1B grants drive wstrb 4'b0000, wdata 0.
REQ-014 iomem outputs SHALL stay constant for the whole AKTIF state.
REQ-015 iomem_ready high at edge k in AKTIF: iomem_valid low, grantee ready_o high, rdata_o = iomem_rdata (registered at k), go BITTI, all from edge k.
REQ-016 BITTI: one cycle, ready_o low again, valid inputs ignored, -> BOS; minimum gap between back-to-back grants = 2 cycles after completion.
REQ-017 rdata_o SHALL hold last captured value until the next completion for that requester; non-granted requester's ready_o stays 0.
REQ-018 Arbitration with ANABELLEK_ROUND_ROBIN_EN undefined: fixed priority, L1V over L1B on simultaneous valid.
REQ-019 Timeout: 8-bit counter cleared on grant, incremented each AKTIF cycle without iomem_ready; reaching ZAMAN_ASIMI -> behave as REQ-015 with rdata_o = 32'h0000_0000 and hata_o pulsed.
REQ-020 iomem_ready in BOS or BITTI SHALL be ignored.
REQ-021 iomem_ready and timeout on the same edge: iomem_ready wins, hata_o stays 0.
REQ-022 Requester dropping valid mid-transaction SHALL NOT abort the iomem cycle; completion still pulses ready_o.

Reset
REQ-023 rst_i high: state BOS, iomem_valid 0, iomem_wstrb 0, iomem_addr 0, iomem_wdata 0, both ready_o 0, both rdata_o 0, hata_o 0, counter 0, priority pointer to L1V, immediately without clock.
REQ-024 Reset mid-transaction SHALL drop iomem_valid asynchronously; no ready_o pulse for the aborted request.

Configuration
REQ-025 Macro ANABELLEK_ROUND_ROBIN_EN defined: round-robin; on simultaneous valid grant the requester not served last; pointer updates at each grant.
REQ-026 Macro undefined: fixed priority per REQ-018; pointer logic absent; all other behaviour identical.

Verification
REQ-027 L1B read addr 17'h00010, memory ready after 3 cycles with 32'hCAFE_0001 -> iomem_addr 32'h0000_0040, wstrb 0, l1b_ready_o one pulse, l1b_rdata_o 32'hCAFE_0001.
REQ-028 L1V write addr 17'h1FFFF, wstrb 4'b0011, wdata 32'h1234_5678 -> iomem_addr 32'h0007_FFFC, wstrb 4'b0011, wdata stable until ready, l1v_ready_o pulse.
REQ-029 Both valid continuously, 4 transactions: fixed build -> L1V,L1V,L1V,L1V; ANABELLEK_ROUND_ROBIN_EN build -> L1V,L1B,L1V,L1B.
REQ-030 ZAMAN_ASIMI=10, iomem_ready never asserted -> ready_o and hata_o pulse on 10th AKTIF cycle, rdata 0, iomem_valid low; ready arriving that same edge -> hata_o 0.
REQ-031 rst_i asserted 2 cycles into L1V transaction -> iomem_valid 0 without clock edge, no l1v_ready_o; next L1B request served normally.

Source files
------------

// File: rtl/anabellek_hakem.sv
// Two-requester (L1B instruction, L1V data) arbiter onto one iomem port with timeout.
// Define ANABELLEK_ROUND_ROBIN_EN for round-robin arbitration (default: fixed, L1V first).
module anabellek_hakem #(
    parameter int unsigned ZAMAN_ASIMI = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        l1b_valid_i,
    input  logic [18:2] l1b_addr_i,
    output logic        l1b_ready_o,
    output logic [31:0] l1b_rdata_o,
    input  logic        l1v_valid_i,
    input  logic [3:0]  l1v_wstrb_i,
    input  logic [18:2] l1v_addr_i,
    input  logic [31:0] l1v_wdata_i,
    output logic        l1v_ready_o,
    output logic [31:0] l1v_rdata_o,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        hata_o
);

    typedef enum logic [1:0] {
        BOS,
        L1B_AKTIF,
        L1V_AKTIF,
        BITTI
    } durum_t;

    localparam logic [8:0] SINIR = 9'(ZAMAN_ASIMI);

    durum_t      durum_q, durum_d;
    logic        iomem_valid_q, iomem_valid_d;
    logic [18:2] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        l1b_ready_q, l1b_ready_d;
    logic        l1v_ready_q, l1v_ready_d;
    logic [31:0] l1b_rdata_q, l1b_rdata_d;
    logic [31:0] l1v_rdata_q, l1v_rdata_d;
    logic        hata_q, hata_d;
    logic [7:0]  sayac_q, sayac_d;
    logic        sec_l1v;
    logic        zaman_doldu;
    logic        bitis;
    logic [31:0] son_veri;

`ifdef ANABELLEK_ROUND_ROBIN_EN
    // ptr_q high: L1V holds priority on the next simultaneous request.
    logic ptr_q, ptr_d;

    assign sec_l1v = l1v_valid_i && (!l1b_valid_i || ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (durum_q == BOS && (l1v_valid_i || l1b_valid_i)) begin
            ptr_d = !sec_l1v;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sec_l1v = l1v_valid_i;
`endif

    assign zaman_doldu = ({1'b0, sayac_q} + 9'd1) == SINIR;
    assign bitis       = iomem_ready || zaman_doldu;
    assign son_veri    = iomem_ready ? iomem_rdata : 32'h0000_0000;

    always_comb begin
        durum_d       = durum_q;
        iomem_valid_d = iomem_valid_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        l1b_ready_d   = 1'b0;
        l1v_ready_d   = 1'b0;
        l1b_rdata_d   = l1b_rdata_q;
        l1v_rdata_d   = l1v_rdata_q;
        hata_d        = 1'b0;
        sayac_d       = sayac_q;

        unique case (durum_q)
            BOS: begin
                if (l1v_valid_i || l1b_valid_i) begin
                    iomem_valid_d = 1'b1;
                    sayac_d       = 8'd0;
                    if (sec_l1v) begin
                        durum_d = L1V_AKTIF;
                        addr_d  = l1v_addr_i;
                        wstrb_d = l1v_wstrb_i;
                        wdata_d = l1v_wdata_i;
                    end else begin
                        durum_d = L1B_AKTIF;
                        addr_d  = l1b_addr_i;
                        wstrb_d = 4'b0000;
                        wdata_d = 32'h0000_0000;
                    end
                end
            end
            L1B_AKTIF, L1V_AKTIF: begin
                if (bitis) begin
                    iomem_valid_d = 1'b0;
                    durum_d       = BITTI;
                    // A real ready on the timeout edge wins and is not an error.
                    hata_d        = !iomem_ready;
                    if (durum_q == L1V_AKTIF) begin
                        l1v_ready_d = 1'b1;
                        l1v_rdata_d = son_veri;
                    end else begin
                        l1b_ready_d = 1'b1;
                        l1b_rdata_d = son_veri;
                    end
                end else begin
                    sayac_d = sayac_q + 8'd1;
                end
            end
            BITTI: begin
                durum_d = BOS;
            end
            default: begin
                durum_d       = BOS;
                iomem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q       <= BOS;
            iomem_valid_q <= 1'b0;
            addr_q        <= '0;
            wstrb_q       <= 4'b0000;
            wdata_q       <= 32'h0000_0000;
            l1b_ready_q   <= 1'b0;
            l1v_ready_q   <= 1'b0;
            l1b_rdata_q   <= 32'h0000_0000;
            l1v_rdata_q   <= 32'h0000_0000;
            hata_q        <= 1'b0;
            sayac_q       <= 8'd0;
        end else begin
            durum_q       <= durum_d;
            iomem_valid_q <= iomem_valid_d;
            addr_q        <= addr_d;
            wstrb_q       <= wstrb_d;
            wdata_q       <= wdata_d;
            l1b_ready_q   <= l1b_ready_d;
            l1v_ready_q   <= l1v_ready_d;
            l1b_rdata_q   <= l1b_rdata_d;
            l1v_rdata_q   <= l1v_rdata_d;
            hata_q        <= hata_d;
            sayac_q       <= sayac_d;
        end
    end

    assign iomem_valid = iomem_valid_q;
    assign iomem_addr  = {13'b0, addr_q, 2'b00};
    assign iomem_wstrb = wstrb_q;
    assign iomem_wdata = wdata_q;
    assign l1b_ready_o = l1b_ready_q;
    assign l1b_rdata_o = l1b_rdata_q;
    assign l1v_ready_o = l1v_ready_q;
    assign l1v_rdata_o = l1v_rdata_q;
    assign hata_o      = hata_q;

endmodule
